// File: rtl/ipu_pkg.sv
// Shared types and constants for the IPU register-bus master.
// Covers the FSM state encoding, the control/data register map and the bus request bundle.
package ipu_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_WR_DATA, S_WR_CTRL, S_TXP_A, S_TXP_B, S_TXW,
      S_RXP_A, S_RXP_B, S_RD_A, S_RD_B, S_CLR
   } ipu_state_e;

   localparam int CTRL_SEND_BIT = 0;
   localparam int CTRL_RX_BIT   = 1;

   localparam logic SEL_CTRL = 1'b0;
   localparam logic SEL_DATA = 1'b1;
   localparam logic ADDR_TX  = 1'b0;
   localparam logic ADDR_RX  = 1'b1;

   localparam logic [31:0] CMD_SEND   = 32'h3;
   localparam logic [31:0] CMD_CLR_RX = 32'h0;

   typedef struct packed {
      logic        wr;
      logic        reg_sel;
      logic        addr;
      logic [31:0] entrada;
   } bus_req_t;

endpackage

// File: rtl/ctrl_bus_ipu.sv
// Register-bus master for the IPU: turns send pulses into tx write/poll sequences
// and, between sends, polls new_rx and fetches received bytes into a held output.
module ctrl_bus_ipu
   import ipu_pkg::*;
#(
   parameter int POLL_DIV = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        send_i,
   input  logic [7:0]  dato_i,
   input  logic [31:0] salida_i,
   output logic        wr_o,
   output logic        reg_sel_o,
   output logic        addr_o,
   output logic [31:0] entrada_o,
   output logic        busy_o,
   output logic [7:0]  rx_byte_o,
   output logic        rx_valid_o
);

   localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);

   ipu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             pending_q;
   logic [7:0]       byte_q, byte_d;
   bus_req_t         req_d, req_q;
   logic             tx_done, accept;
   logic             rx_byte_valid_q;
   logic [7:0]       rx_byte_q;
   logic             unused_salida;

   assign unused_salida = ^salida_i[31:8];

   // A send arriving in the very cycle the frame completes is kept as a new request.
   assign tx_done = (state_q == S_TXP_B) && !salida_i[CTRL_SEND_BIT];
   assign accept  = send_i && (!pending_q || tx_done);
   assign byte_d  = accept ? dato_i : byte_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (pending_q || send_i)  state_d = S_WR_DATA;
                    else if (cnt_q == CNT_LAST) state_d = S_RXP_A;
         S_WR_DATA: state_d = S_WR_CTRL;
         S_WR_CTRL: state_d = S_TXP_A;
         S_TXP_A:   state_d = S_TXP_B;
         S_TXP_B:   state_d = salida_i[CTRL_SEND_BIT] ? S_TXW : S_IDLE;
         S_TXW:     if (cnt_q == CNT_LAST) state_d = S_TXP_A;
         S_RXP_A:   state_d = S_RXP_B;
         S_RXP_B:   state_d = salida_i[CTRL_RX_BIT] ? S_RD_A : S_IDLE;
         S_RD_A:    state_d = S_RD_B;
         S_RD_B:    state_d = S_CLR;
         S_CLR:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Bus outputs are decoded from the next state so the registered copy lines up with state_q.
   always_comb begin
      req_d = '0;
      case (state_d)
         S_WR_DATA: begin
            req_d.wr      = 1'b1;
            req_d.reg_sel = SEL_DATA;
            req_d.addr    = ADDR_TX;
            req_d.entrada = {24'h0, byte_d};
         end
         S_WR_CTRL: begin
            req_d.wr      = 1'b1;
            req_d.reg_sel = SEL_CTRL;
            req_d.entrada = CMD_SEND;
         end
         S_RD_A, S_RD_B: begin
            req_d.reg_sel = SEL_DATA;
            req_d.addr    = ADDR_RX;
         end
         S_CLR: begin
            req_d.wr      = 1'b1;
            req_d.reg_sel = SEL_CTRL;
            req_d.entrada = CMD_CLR_RX;
         end
         default: req_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) req_q <= '0;
      else     req_q <= req_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= 1'b0;
         byte_q    <= 8'h00;
      end else if (accept) begin
         pending_q <= 1'b1;
         byte_q    <= dato_i;
      end else if (tx_done) begin
         pending_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_byte_q       <= 8'h00;
         rx_byte_valid_q <= 1'b0;
      end else begin
         rx_byte_valid_q <= (state_q == S_RD_B);
         if (state_q == S_RD_B) rx_byte_q <= salida_i[7:0];
      end
   end

   assign wr_o       = req_q.wr;
   assign reg_sel_o  = req_q.reg_sel;
   assign addr_o     = req_q.addr;
   assign entrada_o  = req_q.entrada;
   assign busy_o     = pending_q;
   assign rx_byte_o  = rx_byte_q;
   assign rx_valid_o = rx_byte_valid_q;

endmodule

// File: tb/tb_ctrl_bus_ipu.sv
// Directed bench for ctrl_bus_ipu against a small behavioural IPU register model.
module tb_ctrl_bus_ipu;

   localparam int P = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        send_i = 1'b0;
   logic [7:0]  dato_i = 8'h00;
   logic [31:0] salida_i;
   logic        wr_o, reg_sel_o, addr_o, busy_o, rx_valid_o;
   logic [31:0] entrada_o;
   logic [7:0]  rx_byte_o;

   ctrl_bus_ipu #(.POLL_DIV(P)) dut (
      .clk(clk), .rst(rst), .send_i(send_i), .dato_i(dato_i), .salida_i(salida_i),
      .wr_o(wr_o), .reg_sel_o(reg_sel_o), .addr_o(addr_o), .entrada_o(entrada_o),
      .busy_o(busy_o), .rx_byte_o(rx_byte_o), .rx_valid_o(rx_valid_o)
   );

   always #5 clk = ~clk;

   // IPU register model
   logic       ipu_send, ipu_newrx;
   logic [7:0] ipu_tx, ipu_rx;
   int         ipu_cnt;
   int         tx_delay = 10;
   logic       inj_req = 1'b0;
   logic [7:0] inj_data = 8'h00;
   int         frames = 0;
   logic [7:0] last_frame = 8'h00;
   int         clr_cyc = 0;
   int         cyc = 0;
   int         wr_cnt = 0;
   int         rx_pulses = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   assign salida_i = !reg_sel_o ? {30'h0, ipu_newrx, ipu_send}
                   : (addr_o ? {24'h0, ipu_rx} : {24'h0, ipu_tx});

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ipu_send <= 1'b0; ipu_newrx <= 1'b0; ipu_tx <= 8'h00; ipu_rx <= 8'h00; ipu_cnt <= 0;
      end else begin
         if (inj_req) begin ipu_newrx <= 1'b1; ipu_rx <= inj_data; end
         if (ipu_send) begin
            if (ipu_cnt <= 1) begin ipu_send <= 1'b0; clr_cyc <= cyc + 1; end
            else ipu_cnt <= ipu_cnt - 1;
         end
         if (wr_o) begin
            if (!reg_sel_o) begin
               if (entrada_o[0] && !ipu_send) begin
                  ipu_send <= 1'b1; ipu_cnt <= tx_delay;
                  frames <= frames + 1; last_frame <= ipu_tx;
               end
               if (!entrada_o[1]) ipu_newrx <= 1'b0;
            end else if (!addr_o) begin
               ipu_tx <= entrada_o[7:0];
            end
         end
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && wr_o) wr_cnt <= wr_cnt + 1;
      if (!rst && rx_valid_o) rx_pulses <= rx_pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic wait_busy_low(input string tag, input int max);
      int n = 0;
      while (busy_o && n < max) begin step(); n++; end
      chk(tag, {31'h0, busy_o}, 32'h0);
   endtask

   task automatic wait_rx(input string tag, input int max);
      int n = 0;
      while (!rx_valid_o && n < max) begin step(); n++; end
      chk(tag, {31'h0, rx_valid_o}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, f0, p0, lat;
      step(); step();
      chk("rst_wr", {31'h0, wr_o}, 0);
      chk("rst_sel", {31'h0, reg_sel_o}, 0);
      chk("rst_addr", {31'h0, addr_o}, 0);
      chk("rst_entrada", entrada_o, 0);
      chk("rst_busy", {31'h0, busy_o}, 0);
      chk("rst_rxbyte", {24'h0, rx_byte_o}, 0);
      chk("rst_rxvalid", {31'h0, rx_valid_o}, 0);
      rst = 1'b0;

      // reset in the middle of WR_CTRL
      send_i = 1'b1; dato_i = 8'h5A;
      step(); send_i = 1'b0;
      chk("r_wrdata", {31'h0, wr_o}, 1);
      step();
      chk("r_wrctrl", entrada_o, 32'h3);
      rst = 1'b1; #1;
      chk("r_abort_wr", {31'h0, wr_o}, 0);
      chk("r_abort_entrada", entrada_o, 0);
      chk("r_abort_busy", {31'h0, busy_o}, 0);
      w0 = wr_cnt;
      step(); step(); rst = 1'b0;
      repeat (3*P) step();
      chk("r_no_wr", wr_cnt - w0, 0);
      chk("r_no_frame", frames, 0);

      // single frame of 8'hA5
      do_reset();
      tx_delay = 200;
      send_i = 1'b1; dato_i = 8'hA5;
      step(); send_i = 1'b0;
      chk("t2_busy", {31'h0, busy_o}, 1);
      chk("t2_d_wr", {31'h0, wr_o}, 1);
      chk("t2_d_sel", {31'h0, reg_sel_o}, 1);
      chk("t2_d_addr", {31'h0, addr_o}, 0);
      chk("t2_d_data", entrada_o, 32'hA5);
      step();
      chk("t2_c_wr", {31'h0, wr_o}, 1);
      chk("t2_c_sel", {31'h0, reg_sel_o}, 0);
      chk("t2_c_data", entrada_o, 32'h3);
      step();
      chk("t2_poll_wr", {31'h0, wr_o}, 0);
      chk("t2_poll_entrada", entrada_o, 0);
      wait_busy_low("t2_done", 400);
      lat = cyc - clr_cyc;
      chk("t2_latency_ok", {31'h0, (lat >= 0 && lat <= P+3)}, 1);
      chk("t2_frames", frames, 1);
      chk("t2_byte", {24'h0, last_frame}, 32'hA5);

      // second send during a frame is dropped
      tx_delay = 60; f0 = frames;
      send_i = 1'b1; dato_i = 8'h11;
      step(); send_i = 1'b0;
      repeat (8) step();
      send_i = 1'b1; dato_i = 8'h22;
      step(); send_i = 1'b0;
      wait_busy_low("t4_done", 300);
      chk("t4_frames", frames - f0, 1);
      chk("t4_byte", {24'h0, last_frame}, 32'h11);
      repeat (3*P) step();
      chk("t4_idle_busy", {31'h0, busy_o}, 0);
      chk("t4_no_extra", frames - f0, 1);

      // send in the cycle pending clears
      do_reset();
      tx_delay = 10; f0 = frames;
      send_i = 1'b1; dato_i = 8'h44;
      step(); send_i = 1'b0;
      chk("t6_first", entrada_o, 32'h44);
      repeat (21) step();
      send_i = 1'b1; dato_i = 8'h99;
      step(); send_i = 1'b0;
      chk("t6_busy_held", {31'h0, busy_o}, 1);
      chk("t6_gap_wr", {31'h0, wr_o}, 0);
      step();
      chk("t6_wr2", {31'h0, wr_o}, 1);
      chk("t6_sel2", {31'h0, reg_sel_o}, 1);
      chk("t6_data2", entrada_o, 32'h99);
      wait_busy_low("t6_done", 200);
      chk("t6_frames", frames - f0, 2);
      chk("t6_byte", {24'h0, last_frame}, 32'h99);

      // send and new_rx together: tx first, then rx
      p0 = rx_pulses;
      inj_req = 1'b1; inj_data = 8'h77;
      send_i = 1'b1; dato_i = 8'h66;
      step(); inj_req = 1'b0; send_i = 1'b0;
      chk("t5_tx_first", {31'h0, wr_o}, 1);
      chk("t5_tx_sel", {31'h0, reg_sel_o}, 1);
      chk("t5_tx_data", entrada_o, 32'h66);
      wait_busy_low("t5_done", 200);
      chk("t5_no_rx_yet", rx_pulses - p0, 0);
      wait_rx("t5_rx", 4*P + 10);
      chk("t5_rx_byte", {24'h0, rx_byte_o}, 32'h77);
      chk("t5_frame_byte", {24'h0, last_frame}, 32'h66);

      // plain rx of 8'h3C
      repeat (5) step();
      p0 = rx_pulses;
      inj_req = 1'b1; inj_data = 8'h3C;
      step(); inj_req = 1'b0;
      wait_rx("t3_rx", 3*P + 10);
      chk("t3_rx_byte", {24'h0, rx_byte_o}, 32'h3C);
      chk("t3_clr_wr", {31'h0, wr_o}, 1);
      chk("t3_clr_sel", {31'h0, reg_sel_o}, 0);
      chk("t3_clr_data", entrada_o, 32'h0);
      step();
      chk("t3_pulse_end", {31'h0, rx_valid_o}, 0);
      chk("t3_wr_end", {31'h0, wr_o}, 0);
      chk("t3_hold", {24'h0, rx_byte_o}, 32'h3C);
      repeat (3*P) step();
      chk("t3_one_pulse", rx_pulses - p0, 1);
      chk("t3_newrx_clr", {31'h0, ipu_newrx}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_bus_ipu.md
# ctrl_bus_ipu

Register-bus master that drives the IPU (UART peripheral) register port in place of the manual test generator. It turns a debounced send pulse plus an 8-bit switch value into the IPU write/poll sequence for a UART transmit. Between sends it polls the IPU receive flag, reads each received byte and presents it on a holding output for the LEDs. It sits directly upstream of the IPU, inside top, after the debouncers and clock wizard.

## Interface
- POLL_DIV, 16: idle cycles between successive control-register polls (≥2)
- clk  in  1  system clock (10 MHz domain)
- rst  in  1  asynchronous, active-high reset
- send_i  in  1  one-cycle send request (debounced)
- dato_i  in  8  byte to transmit, sampled on the send_i cycle
- salida_i  in  32  IPU read data
- wr_o  out  1  IPU write strobe
- reg_sel_o  out  1  0 = control register, 1 = data registers
- addr_o  out  1  data register select: 0 = tx data, 1 = rx data
- entrada_o  out  32  IPU write data
- busy_o  out  1  transmit in progress or request pending
- rx_byte_o  out  8  last received byte (held)
- rx_valid_o  out  1  one-cycle pulse when rx_byte_o updates

## Operation
- IPU register map:
  - Control register: bit0 = send. The master writes 1; the IPU clears it when the frame is done; writing 0 has no effect.
  - Control register: bit1 = new_rx. The IPU sets it; writing 0 clears it; writing 1 has no effect.
  - Data registers: addr 0 = tx byte, addr 1 = rx byte. Data is in [7:0]; the upper bits are ignored or read as 0.
- Read protocol:
  - The master drives reg_sel_o/addr_o with wr_o=0 for one cycle (xx_A state).
  - It samples salida_i in the following cycle (xx_B state), with the address held.
- States:
  - IDLE: the poll counter counts to POLL_DIV-1. A pending request goes to WR_DATA; otherwise a counter expiry goes to RXP_A.
  - WR_DATA: wr_o=1, reg_sel=1, addr=0, entrada={24'b0, latched byte} → WR_CTRL.
  - WR_CTRL: wr_o=1, reg_sel=0, entrada=32'h3 → TXP_A.
  - TXP_A / TXP_B: read control. If bit0=1, go to TXW (wait POLL_DIV cycles), then TXP_A. If bit0=0, clear pending and go to IDLE.
  - RXP_A / RXP_B: read control. If bit1=1 → RD_A; else → IDLE.
  - RD_A / RD_B: read addr 1. In RD_B, load rx_byte_o from salida_i[7:0] and pulse rx_valid_o → CLR.
  - CLR: wr_o=1, reg_sel=0, entrada=32'h0 → IDLE.
- Request latch (one deep):
  - send_i sets pending and captures dato_i.
  - A send_i while pending is already set is dropped; the first byte is kept.
  - A send_i in the same cycle that pending clears is accepted as a new request.
- Priority: a pending send beats an rx poll in IDLE. An rx-poll sequence already started runs to CLR/IDLE before the send is served.
- busy_o = pending.
- Outputs are registered. wr_o is high for exactly one cycle per write. entrada_o is 0 whenever wr_o=0.

## Timing
- Reset values: wr_o=0, reg_sel_o=0, addr_o=0, entrada_o=0, busy_o=0, rx_byte_o=8'h00, rx_valid_o=0. State = IDLE, poll counter = 0, pending = 0.
- Reset mid-sequence aborts immediately with no further bus writes. The IPU resets on the same rst.
- send_i at cycle n, FSM in IDLE:
  - busy_o=1 at n+1.
  - WR_DATA strobe at n+1.
  - WR_CTRL strobe at n+2.
  - First TXP_A at n+3.
- Done detection: busy_o falls at most POLL_DIV+3 cycles after the IPU clears bit0.
- Rx: a new byte is reported at most POLL_DIV+4 cycles after new_rx is set, provided no transmit is active. rx_valid_o pulses in the RD_B cycle+1 (registered).
- Poll counter resets on every entry to IDLE.

## Structure
- Package ipu_pkg holds:
  - state enum
  - CTRL_SEND_BIT=0, CTRL_RX_BIT=1
  - ADDR_TX=0, ADDR_RX=1
  - CMD_SEND=32'h3, CMD_CLR_RX=32'h0
- Single module, no sub-module. The poll counter is an inline register.

## Test plan
- Reset: assert rst mid-WR_CTRL → all outputs 0 next edge, no wr_o until a new send_i.
- Send 8'hA5, IPU model clears bit0 after 200 cycles → data write 32'hA5 to (1,0), control write 32'h3, busy_o falls within POLL_DIV+3 cycles of the clear.
- IPU model sets new_rx with rx data 8'h3C → rx_byte_o=8'h3C, single rx_valid_o pulse, then control write 32'h0.
- Two send_i pulses during a transmit (8'h11 then 8'h22) → only 8'h11 is sent, and busy_o returns to 0 after one frame.
- send_i and new_rx both pending in IDLE → tx sequence first, then the rx read at the next poll; no lost byte.
- send_i in the cycle pending clears → second frame starts with the new dato_i value.
